// File: rtl/issue_pkg.sv
// Shared types and constants for the tile issue controller.
package issue_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned REG_AW   = 3;
  localparam int unsigned NUM_REGS = 8;

  // Instruction field positions (LSB of each field)
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned RD_LSB   = 9;
  localparam int unsigned RS0_LSB  = 6;
  localparam int unsigned RS1_LSB  = 3;
  localparam int unsigned RSVD_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_MUL = 4'h3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs0;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rsvd;
  } instr_t;

  // Split a raw instruction word into its fields.
  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.opcode = raw[OP_LSB   +: OP_W];
    d.rd     = raw[RD_LSB   +: REG_AW];
    d.rs0    = raw[RS0_LSB  +: REG_AW];
    d.rs1    = raw[RS1_LSB  +: REG_AW];
    d.rsvd   = raw[RSVD_LSB +: REG_AW];
    return d;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Small synchronous FIFO holding pending instructions.
module issue_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             clear_b,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             one_left
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign one_left = (count == CNT_W'(1));
  assign dout     = mem[rptr];

  // Storage array; contents are don't-care while empty so no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tile_issue_controller.sv
// Issue stage for computationTile: instruction FIFO, 8-entry register file,
// opcode-dependent latency wait and writeback. Build macro
// ISSUE_PERF_CNT_EN adds saturating retired/stall counters.
module tile_issue_controller
  import issue_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ALU_LAT    = 1,
  parameter int unsigned MUL_LAT    = 5
) (
  input  logic               clock,
  input  logic               clear_b,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_data,
  output logic               instr_ready,
  input  logic               wr,
  input  logic [REG_AW-1:0]  wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  output logic [WIDTH-1:0]   rd_data,
  output logic [OP_W-1:0]    tile_opcode,
  output logic [WIDTH-1:0]   tile_data0,
  output logic [WIDTH-1:0]   tile_data1,
  input  logic [WIDTH-1:0]   tile_result,
  output logic               busy,
  output logic               done
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]        retired_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int unsigned MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   rf [NUM_REGS];
  logic [CNT_W-1:0]   lat_cnt;
  logic [REG_AW-1:0]  wb_rd;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_one_left;
  logic [INSTR_W-1:0] fifo_head;
  instr_t             head;
  logic               head_nop;
  logic               issue_en;
  logic               wb_en;
  logic               lat_last;
  logic               unused_rsvd;

  assign instr_ready = !fifo_full;
  assign fifo_push   = instr_valid && !fifo_full;

  issue_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .clear_b  (clear_b),
    .push     (fifo_push),
    .din      (instr_data),
    .pop      (fifo_pop),
    .dout     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .one_left (fifo_one_left)
  );

  assign head        = decode_instr(fifo_head);
  assign unused_rsvd = ^head.rsvd;
  assign head_nop    = (head.opcode == OP_NOP);
  assign lat_last    = (lat_cnt == CNT_W'(1));
  assign rd_data     = rf[wr_addr];
  assign busy        = (state != IDLE) || !fifo_empty;

  // State register.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a NOP retires from ISSUE without visiting WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!fifo_empty) state_nxt = ISSUE;
      ISSUE: begin
        if (!head_nop)          state_nxt = WAIT;
        else if (fifo_one_left) state_nxt = IDLE;
        else                    state_nxt = ISSUE;
      end
      WAIT:  if (lat_last) state_nxt = fifo_empty ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    fifo_pop = 1'b0;
    issue_en = 1'b0;
    wb_en    = 1'b0;
    case (state)
      ISSUE: begin
        fifo_pop = 1'b1;
        issue_en = 1'b1;
      end
      WAIT:    wb_en = lat_last;
      default: ;
    endcase
  end

  // Tile operand/opcode registers, latency counter and retire pulse.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      tile_opcode <= OP_NOP;
      tile_data0  <= '0;
      tile_data1  <= '0;
      lat_cnt     <= '0;
      wb_rd       <= '0;
      done        <= 1'b0;
    end else begin
      done <= wb_en || (issue_en && head_nop);
      if (issue_en) begin
        tile_opcode <= head.opcode;
        tile_data0  <= rf[head.rs0];
        tile_data1  <= rf[head.rs1];
        wb_rd       <= head.rd;
        lat_cnt     <= (head.opcode == OP_MUL) ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - CNT_W'(1);
        if (state_nxt == IDLE) tile_opcode <= OP_NOP;
      end
    end
  end

  // Register file; a writeback beats a host write to the same register.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wb_en && (wb_rd == REG_AW'(i)))      rf[i] <= tile_result;
        else if (wr && (wr_addr == REG_AW'(i)))  rf[i] <= wr_data;
      end
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  // Saturating retire and back-pressure counters.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (done && (retired_cnt != 16'hFFFF))
        retired_cnt <= retired_cnt + 16'd1;
      if (instr_valid && fifo_full && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tile_issue_controller.sv
// Directed bench for tile_issue_controller with a register-file model and
// a retire-order scoreboard.
module tb_tile_issue_controller;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ALU_LAT    = 1;
  localparam int unsigned MUL_LAT    = 5;

  logic             clock = 1'b0;
  logic             clear_b = 1'b0;
  logic             instr_valid = 1'b0;
  logic [15:0]      instr_data = '0;
  logic             instr_ready;
  logic             wr = 1'b0;
  logic [2:0]       wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] rd_data;
  logic [3:0]       tile_opcode;
  logic [WIDTH-1:0] tile_data0;
  logic [WIDTH-1:0] tile_data1;
  logic [WIDTH-1:0] tile_result;
  logic             busy;
  logic             done;
`ifdef ISSUE_PERF_CNT_EN
  logic [15:0]      retired_cnt;
  logic [15:0]      stall_cnt;
`endif

  typedef struct {
    logic        wb;
    logic [2:0]  rd;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        ret_q[$];
  logic [15:0] model_rf [8];
  int          passed = 0;
  int          total = 0;
  int          done_cnt = 0;
  int          stall_exp = 0;
  int          retire_exp = 0;
  int          dc0;

  always #5 clock = ~clock;

  tile_issue_controller #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ALU_LAT    (ALU_LAT),
    .MUL_LAT    (MUL_LAT)
  ) dut (
    .clock       (clock),
    .clear_b     (clear_b),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_ready (instr_ready),
    .wr          (wr),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .tile_opcode (tile_opcode),
    .tile_data0  (tile_data0),
    .tile_data1  (tile_data1),
    .tile_result (tile_result),
    .busy        (busy),
    .done        (done)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  // Behavioural tile: add, sub, mul, xor, otherwise and.
  function automatic logic [15:0] tile_fn(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      4'h1:    return a + b;
      4'h2:    return a - b;
      4'h3:    return a * b;
      4'h4:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  always_comb tile_result = tile_fn(tile_opcode, tile_data0, tile_data1);

  // Reserved bits set non-zero so they must be ignored.
  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs0, input logic [2:0] rs1);
    return {op, rd, rs0, rs1, 3'b101};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [15:0] d);
    wr = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr = 1'b0;
    model_rf[a] = d;
  endtask

  // Offer one instruction, wait (bounded) for ready, and record its expected effect.
  task automatic push_instr(input logic [15:0] ins);
    int          n;
    logic [15:0] v;
    n = 0;
    instr_valid = 1'b1;
    instr_data  = ins;
    while (!instr_ready && n < 64) begin
      stall_exp++;
      tick();
      n++;
    end
    check("push_ready", 32'(instr_ready), 1);
    tick();
    instr_valid = 1'b0;
    retire_exp++;
    if (ins[15:12] == 4'h0) begin
      exp_q.push_back('{1'b0, 3'd0, 16'h0});
    end else begin
      v = tile_fn(ins[15:12], model_rf[ins[8:6]], model_rf[ins[5:3]]);
      model_rf[ins[11:9]] = v;
      exp_q.push_back('{1'b1, ins[11:9], v});
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("drain_busy", 32'(busy), 0);
    tick();
  endtask

  task automatic check_retired();
    exp_t e;
    while (ret_q.size() != 0) begin
      e = ret_q.pop_front();
      if (e.wb) begin
        wr_addr = e.rd;
        tick();
        check("rf_writeback", 32'(rd_data), 32'(e.val));
      end
    end
  endtask

  task automatic check_rf_all();
    for (int i = 0; i < 8; i++) begin
      wr_addr = 3'(i);
      tick();
      check("rf_unchanged", 32'(rd_data), 32'(model_rf[i]));
    end
  endtask

  // Retire monitor: each done pulse consumes the oldest expected instruction.
  always @(negedge clock) begin
    if (clear_b && done === 1'b1) begin
      done_cnt++;
      check("sb_has_entry", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) ret_q.push_back(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) model_rf[i] = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_opcode", 32'(tile_opcode), 0);
    check("rst_data0", 32'(tile_data0), 0);
    check("rst_data1", 32'(tile_data1), 0);
    wr_addr = 3'd3;
    #1;
    check("rst_rf3", 32'(rd_data), 0);
    clear_b = 1'b1;
    tick();
    check("rst_ready", 32'(instr_ready), 1);

    // ALU add: issue timing and operands
    host_write(3'd1, 16'h8ff8);
    host_write(3'd2, 16'h8f07);
    push_instr(mk(4'h1, 3'd3, 3'd1, 3'd2));
    tick();
    check("add_done_c1", 32'(done), 0);
    tick();
    check("add_opcode", 32'(tile_opcode), 1);
    check("add_data0", 32'(tile_data0), 32'h8ff8);
    check("add_data1", 32'(tile_data1), 32'h8f07);
    check("add_done_c2", 32'(done), 0);
    tick();
    check("add_done_c3", 32'(done), 1);
    wait_idle(20);
    check_retired();
    wr_addr = 3'd3;
    tick();
    check("add_rf3", 32'(rd_data), 32'h1eff);

    // Multiply: operands held for MUL_LAT cycles, no early writeback
    host_write(3'd1, 16'h0001);
    host_write(3'd2, 16'h0001);
    push_instr(mk(4'h3, 3'd4, 3'd1, 3'd2));
    wr_addr = 3'd4;
    tick();
    check("mul_done_c1", 32'(done), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("mul_opcode_hold", 32'(tile_opcode), 3);
      check("mul_data0_hold", 32'(tile_data0), 1);
      check("mul_data1_hold", 32'(tile_data1), 1);
      check("mul_no_early_wb", 32'(rd_data), 0);
      check("mul_no_early_done", 32'(done), 0);
    end
    tick();
    check("mul_done", 32'(done), 1);
    check("mul_rf4", 32'(rd_data), 1);
    wait_idle(20);
    check_retired();

    // Six dependent instructions pushed back to back behind a multiply
    host_write(3'd1, 16'h0003);
    host_write(3'd2, 16'h0005);
    dc0 = done_cnt;
    push_instr(mk(4'h3, 3'd3, 3'd1, 3'd2));
    push_instr(mk(4'h1, 3'd4, 3'd3, 3'd1));
    push_instr(mk(4'h2, 3'd5, 3'd4, 3'd2));
    push_instr(mk(4'h4, 3'd6, 3'd5, 3'd4));
    check("fifo3_ready", 32'(instr_ready), 1);
    push_instr(mk(4'h1, 3'd7, 3'd6, 3'd6));
    check("fifo_full_ready", 32'(instr_ready), 0);
    push_instr(mk(4'h3, 3'd0, 3'd7, 3'd1));
    wait_idle(100);
    check("burst_done_cnt", 32'(done_cnt - dc0), 6);
    check("burst_retired", 32'(ret_q.size()), 6);
    check_retired();

    // NOP: one-cycle retire, registers untouched
    dc0 = done_cnt;
    push_instr(16'h0000);
    tick();
    check("nop_done_c1", 32'(done), 0);
    tick();
    check("nop_done_c2", 32'(done), 1);
    check("nop_opcode", 32'(tile_opcode), 0);
    wait_idle(20);
    check("nop_done_cnt", 32'(done_cnt - dc0), 1);
    check("nop_retired", 32'(ret_q.size()), 1);
    check_retired();
    check_rf_all();
`ifdef ISSUE_PERF_CNT_EN
    check("perf_retired", 32'(retired_cnt), 32'(retire_exp));
    check("perf_stall", 32'(stall_cnt), 32'(stall_exp));
`endif

    // Reset during the third WAIT cycle of a multiply
    push_instr(mk(4'h3, 3'd3, 3'd1, 3'd2));
    push_instr(mk(4'h1, 3'd5, 3'd1, 3'd2));
    tick();
    tick();
    tick();
    check("abort_busy_before", 32'(busy), 1);
    clear_b = 1'b0;
    exp_q.delete();
    ret_q.delete();
    for (int i = 0; i < 8; i++) model_rf[i] = '0;
    retire_exp = 0;
    stall_exp = 0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(instr_ready), 1);
    check("abort_opcode", 32'(tile_opcode), 0);
    check("abort_done", 32'(done), 0);
    tick();
    tick();
    clear_b = 1'b1;
    dc0 = done_cnt;
    repeat (12) tick();
    check("abort_no_done", 32'(done_cnt - dc0), 0);
    check("abort_idle", 32'(busy), 0);
    wr_addr = 3'd3;
    tick();
    check("abort_rf3", 32'(rd_data), 0);

    // Host write colliding with writeback to the same register
    host_write(3'd1, 16'h5555);
    host_write(3'd2, 16'h0000);
    push_instr(mk(4'h1, 3'd3, 3'd1, 3'd2));
    tick();
    tick();
    wr = 1'b1; wr_addr = 3'd3; wr_data = 16'hAAAA;
    tick();
    wr = 1'b0;
    check("coll_done", 32'(done), 1);
    wait_idle(20);
    check_retired();
    wr_addr = 3'd3;
    tick();
    check("coll_rf3", 32'(rd_data), 32'h5555);

    // Host write to a different register on the writeback edge
    push_instr(mk(4'h1, 3'd4, 3'd1, 3'd2));
    tick();
    tick();
    wr = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
    tick();
    wr = 1'b0;
    model_rf[5] = 16'h1234;
    wait_idle(20);
    check_retired();
    wr_addr = 3'd5;
    tick();
    check("both_rf5", 32'(rd_data), 32'h1234);
`ifdef ISSUE_PERF_CNT_EN
    check("perf_retired_post", 32'(retired_cnt), 32'(retire_exp));
    check("perf_stall_post", 32'(stall_cnt), 32'(stall_exp));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tile_issue_controller.md
Name: tile_issue_controller

Overview:
Upstream stage of computationTile. Accepts 16-bit instructions through a valid/ready port into a small FIFO and reads operands from an 8x16 register file. Drives opcode/data_in0/data_in1 to the tile, holds them for an opcode-dependent latency, then writes the tile's data_out back to the destination register. The host preloads and reads back registers through a side port.

Parameters:
WIDTH, 16, datapath width; matches tile data ports
FIFO_DEPTH, 4, instruction FIFO entries; power of two, at least 2
ALU_LAT, 1, cycles the tile needs for every opcode except 4'h3
MUL_LAT, 5, cycles the tile needs for opcode 4'h3 (multiply)

Ports:
clock  in  1  system clock, rising edge
clear_b  in  1  reset, asynchronous, active-low
instr_valid  in  1  instruction offered
instr_data  in  16  [15:12] opcode, [11:9] rd, [8:6] rs0, [5:3] rs1, [2:0] reserved (ignored)
instr_ready  out  1  FIFO not full
wr  in  1  host register write enable
wr_addr  in  3  host write/read register index
wr_data  in  WIDTH  host write data
rd_data  out  WIDTH  combinational rf[wr_addr]
tile_opcode  out  4  to tile opcode
tile_data0  out  WIDTH  to tile data_in0
tile_data1  out  WIDTH  to tile data_in1
tile_result  in  WIDTH  from tile data_out
busy  out  1  state != IDLE or FIFO non-empty
done  out  1  one-cycle pulse per retired instruction

Behaviour:
- Reset (clear_b low, async): state IDLE, FIFO flushed, rf[0..7]=0, tile_opcode=0, tile_data0/1=0, done=0, latency counter=0.
  - instr_ready=1 once reset is released.
  - Reset mid-WAIT aborts the instruction: no writeback, no done pulse.
- FIFO: push on instr_valid & instr_ready. Pop only in ISSUE. instr_ready = !full.
  - Push and pop in the same cycle while full is not possible, because ready is low when full.
  - Push and pop in the same cycle at any other occupancy: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, ISSUE, WAIT.
  - IDLE: tile_opcode=0. Go to ISSUE when the FIFO is non-empty.
  - ISSUE, one cycle: pop the head. On the edge, register tile_opcode=op, tile_data0=rf[rs0], tile_data1=rf[rs1].
    - Load counter = (op==4'h3 ? MUL_LAT : ALU_LAT).
    - op==4'h0 is a NOP: no WAIT, no writeback, done pulses. Next state is ISSUE if the FIFO is non-empty, otherwise IDLE.
    - Any other op goes to WAIT.
  - WAIT: tile_* outputs held stable. Counter decrements each cycle.
    - When counter==1, on the edge: rf[rd] <= tile_result, done=1 for the following cycle, counter=0.
    - Next state is ISSUE if the FIFO is non-empty, otherwise IDLE.
- Timing: an instruction retires 1+LAT cycles after entering ISSUE. Back-to-back throughput is 1+LAT cycles per instruction.
- Hazards: single issue, in-order, each instruction completes before the next is issued. No forwarding needed.
- Operand reads see all writebacks and host writes from earlier edges.
- Host write during busy is allowed.
  - Same-edge host write and writeback to the same rd: writeback wins, host write dropped.
  - Different registers: both take effect.
- Reserved bits [2:0] are ignored. Opcodes 4'h1..4'hF pass through to the tile unmodified.

Optional Feature:
ISSUE_PERF_CNT_EN
- Defined: adds outputs retired_cnt[15:0] and stall_cnt[15:0].
  - retired_cnt increments on each done pulse.
  - stall_cnt increments on each cycle with instr_valid & !instr_ready.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and logic absent; the rest of the behaviour is identical.

Decomposition:
- Package issue_pkg:
  - opcode constants OP_NOP=4'h0, OP_MUL=4'h3
  - instruction field bit positions
  - state enum {IDLE, ISSUE, WAIT}
  - typedef instr_t (packed opcode/rd/rs0/rs1/rsvd)
- Sub-module issue_fifo: parameterised WIDTH=16 x FIFO_DEPTH, with push/pop/full/empty. The top holds the FSM, register file and latency counter.

Test Plan:
- Reset then host wr r1=16'h8ff8, r2=16'h8f07. Push {4'h1,rd=3,rs0=1,rs1=2}. Tile model returns a+b.
  - Required: tile_data0=16'h8ff8, tile_data1=16'h8f07, tile_opcode=1.
  - Required: done exactly 2 cycles after ISSUE; rd_data(addr 3)=16'h1eff.
- r1=1, r2=1, push op 4'h3 rd=4.
  - Required: tile_* stable for 5 cycles; done 6 cycles after ISSUE; rf[4]=model product.
  - Required: no write before that cycle.
- Push 6 instructions in consecutive cycles while the first is a MUL.
  - Required: instr_ready falls after the FIFO holds 4.
  - Required: all retire in order; done count=6; no instruction lost or duplicated.
- Push a NOP (16'h0000).
  - Required: done pulses 1 cycle after ISSUE; every register unchanged; tile_opcode=0.
- Assert clear_b low on the 3rd WAIT cycle of a MUL.
  - Required: immediately state IDLE and FIFO empty; rf[rd]=0; no done pulse.
- Host writes rd=3 with 16'hAAAA on the same edge as a writeback of 16'h5555 to rd=3.
  - Required: rf[3]=16'h5555.
  - With ISSUE_PERF_CNT_EN: retired_cnt and stall_cnt match the stimulus counts.
